pes_sipo_deser: RTL

- Receive-side counterpart to the team's serial shift path: recovers framed words from a 1-bit-per-clock serial stream and presents them as parallel words.
- Frame format: start bit, WIDTH data bits LSB first, then stop bit.
- A one-entry output buffer with valid/ready handshake feeds downstream logic.
- Frame errors and overruns are flagged as single-cycle pulses.

---
 rtl/pes_sipo_deser.sv | 54 +++++
 1 files changed

// File: rtl/pes_sipo_deser.sv
// pes_sipo_deser: receives framed serial words (start, WIDTH data bits LSB first, stop)
// and presents them through a one-entry valid/ready buffer with frame-error and overrun pulses.
module pes_sipo_deser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sr;
  logic good, load;
  always_comb begin
    state_n = (state == IDLE) ? (serial_in ? IDLE : DATA) :
              (state == DATA) ? ((cnt == CW'(WIDTH - 1)) ? STOP : DATA) : IDLE;
  end
  assign good = (state == STOP) && serial_in;
  // a same-edge accept frees the buffer, so the new word loads without a bubble
  assign load = good && (!data_valid || data_ready);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      sr         <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state     <= state_n;
      busy      <= state_n != IDLE;
      frame_err <= (state == STOP) && !serial_in;
      overrun   <= good && !load;
      cnt       <= (state == DATA) ? cnt + CW'(1) : '0;
      if (state == DATA) sr[cnt] <= serial_in;
      if (load) begin
        data_out   <= sr;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end
endmodule
